// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - sequencing/control unit for the one-cycle CPU (PC, call stack, run/halt/fault, decode)
// Optional loop counter with LDC/DJNZ opcodes is enabled by defining CPU_CTRL_LOOP_EN.
module cpu_ctrl #(
   parameter int WIDTH          = 8,
   parameter int IWIDTH         = 5,
   parameter int REG_F_SEL_SIZE = 4,
   parameter int IN_B_SEL_SIZE  = 2,
   parameter int STACK_DEPTH    = 4
) (
   input  logic                              CLK,
   input  logic                              RST_N,
   input  logic [IWIDTH+IN_B_SEL_SIZE+WIDTH-1:0] INSTR,
   input  logic                              Z,
   output logic [WIDTH-1:0]                  PC,
   output logic [REG_F_SEL_SIZE-1:0]         REG_F_SEL,
   output logic                              EN_REG_F,
   output logic [WIDTH-1:0]                  D_MEM_ADDR,
   output logic                              D_MEM_ADDR_MODE,
   output logic                              EN_D_MEM,
   output logic [IN_B_SEL_SIZE-1:0]          IN_B_SEL,
   output logic [WIDTH-1:0]                  IMM,
   output logic [IWIDTH-2:0]                 ALU_OUT,
   output logic                              EN_ACC,
   output logic                              HALTED,
   output logic                              FAULT
);

   localparam int SPW = $clog2(STACK_DEPTH) + 1;

   localparam logic [IWIDTH-1:0] OP_JMP  = {1'b1, (IWIDTH-1)'(1)};
   localparam logic [IWIDTH-1:0] OP_JZ   = {1'b1, (IWIDTH-1)'(2)};
   localparam logic [IWIDTH-1:0] OP_JNZ  = {1'b1, (IWIDTH-1)'(3)};
   localparam logic [IWIDTH-1:0] OP_CALL = {1'b1, (IWIDTH-1)'(4)};
   localparam logic [IWIDTH-1:0] OP_RET  = {1'b1, (IWIDTH-1)'(5)};
   localparam logic [IWIDTH-1:0] OP_STR  = {1'b1, (IWIDTH-1)'(6)};
   localparam logic [IWIDTH-1:0] OP_STM  = {1'b1, (IWIDTH-1)'(7)};
   localparam logic [IWIDTH-1:0] OP_STMI = {1'b1, (IWIDTH-1)'(8)};
   localparam logic [IWIDTH-1:0] OP_HLT  = {1'b1, (IWIDTH-1)'(9)};
`ifdef CPU_CTRL_LOOP_EN
   localparam logic [IWIDTH-1:0] OP_LDC  = {1'b1, (IWIDTH-1)'(10)};
   localparam logic [IWIDTH-1:0] OP_DJNZ = {1'b1, (IWIDTH-1)'(11)};
`endif

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  pc_q, pc_d;
   logic [SPW-1:0]    sp_q, sp_d;
   logic [WIDTH-1:0]  stack_q [STACK_DEPTH];
   logic              push;

   logic [IWIDTH-1:0]        opc;
   logic [IN_B_SEL_SIZE-1:0] bsrc;
   logic [WIDTH-1:0]         operand;
   logic [WIDTH-1:0]         pc_inc;
   logic [SPW-1:0]           sp_m1;

`ifdef CPU_CTRL_LOOP_EN
   logic [WIDTH-1:0]  lc_q, lc_d;
   logic [WIDTH-1:0]  lc_dec;
   assign lc_dec = lc_q - WIDTH'(1);
`endif

   assign {opc, bsrc, operand} = INSTR;
   assign pc_inc     = pc_q + WIDTH'(1);
   assign sp_m1      = sp_q - SPW'(1);
   assign PC         = pc_q;
   assign IMM        = operand;
   assign D_MEM_ADDR = operand;
   assign REG_F_SEL  = operand[REG_F_SEL_SIZE-1:0];
   assign HALTED     = (state_q == ST_HALT) || (state_q == ST_FAULT);
   assign FAULT      = (state_q == ST_FAULT);

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      sp_d            = sp_q;
      push            = 1'b0;
      EN_REG_F        = 1'b0;
      EN_D_MEM        = 1'b0;
      EN_ACC          = 1'b0;
      D_MEM_ADDR_MODE = 1'b0;
      IN_B_SEL        = '0;
      ALU_OUT         = '0;
`ifdef CPU_CTRL_LOOP_EN
      lc_d            = lc_q;
`endif
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            pc_d = pc_inc;
            if (!opc[IWIDTH-1]) begin
               ALU_OUT         = opc[IWIDTH-2:0];
               EN_ACC          = 1'b1;
               IN_B_SEL        = bsrc;
               D_MEM_ADDR_MODE = &bsrc;
            end else begin
               case (opc)
                  OP_JMP: pc_d = operand;
                  OP_JZ:  if (Z)  pc_d = operand;
                  OP_JNZ: if (!Z) pc_d = operand;
                  OP_CALL: begin
                     // A full stack faults without pushing; PC stays on the offending CALL.
                     if (sp_q == SPW'(STACK_DEPTH)) begin
                        state_d = ST_FAULT;
                        pc_d    = pc_q;
                     end else begin
                        push = 1'b1;
                        sp_d = sp_q + SPW'(1);
                        pc_d = operand;
                     end
                  end
                  OP_RET: begin
                     if (sp_q == '0) begin
                        state_d = ST_FAULT;
                        pc_d    = pc_q;
                     end else begin
                        sp_d = sp_m1;
                        pc_d = stack_q[sp_m1[SPW-2:0]];
                     end
                  end
                  OP_STR: EN_REG_F = 1'b1;
                  OP_STM: EN_D_MEM = 1'b1;
                  OP_STMI: begin
                     EN_D_MEM        = 1'b1;
                     D_MEM_ADDR_MODE = 1'b1;
                  end
                  OP_HLT: begin
                     state_d = ST_HALT;
                     pc_d    = pc_q;
                  end
`ifdef CPU_CTRL_LOOP_EN
                  OP_LDC: lc_d = operand;
                  OP_DJNZ: begin
                     lc_d = lc_dec;
                     if (lc_dec != '0) pc_d = operand;
                  end
`endif
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_BOOT;
         pc_q    <= '0;
         sp_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
      end
   end

`ifdef CPU_CTRL_LOOP_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) lc_q <= '0;
      else        lc_q <= lc_d;
   end
`endif

   // Stack storage survives reset; only SP is cleared.
   always_ff @(posedge CLK) begin
      if (push) stack_q[sp_q[SPW-2:0]] <= pc_inc;
   end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - directed self-checking bench for cpu_ctrl
module tb_cpu_ctrl;
   logic        CLK, RST_N, Z;
   logic [14:0] INSTR;
   logic [7:0]  PC, D_MEM_ADDR, IMM;
   logic [3:0]  REG_F_SEL, ALU_OUT;
   logic [1:0]  IN_B_SEL;
   logic        EN_REG_F, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC, HALTED, FAULT;

   logic [14:0] rom [256];
   int n_cmp = 0;
   int n_err = 0;

   cpu_ctrl dut (
      .CLK(CLK), .RST_N(RST_N), .INSTR(INSTR), .Z(Z), .PC(PC),
      .REG_F_SEL(REG_F_SEL), .EN_REG_F(EN_REG_F), .D_MEM_ADDR(D_MEM_ADDR),
      .D_MEM_ADDR_MODE(D_MEM_ADDR_MODE), .EN_D_MEM(EN_D_MEM), .IN_B_SEL(IN_B_SEL),
      .IMM(IMM), .ALU_OUT(ALU_OUT), .EN_ACC(EN_ACC), .HALTED(HALTED), .FAULT(FAULT)
   );

   assign INSTR = rom[PC];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [14:0] ins(input logic [4:0] o, input logic [1:0] b, input logic [7:0] d);
      return {o, b, d};
   endfunction

   task automatic fill_nop();
      for (int i = 0; i < 256; i++) rom[i] = ins(5'b10000, 2'b00, 8'h00);
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Leaves the core in BOOT, sampled at a falling edge.
   task automatic do_reset();
      RST_N = 1'b0;
      Z = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      fill_nop();
      RST_N = 1'b0;
      @(negedge CLK);
      n_cmp++; if (PC !== 8'h00) begin n_err++; $display("FAIL rst_pc got=%h exp=00", PC); end
      n_cmp++; if ({HALTED, FAULT} !== 2'b00) begin n_err++; $display("FAIL rst_flags got=%b exp=00", {HALTED, FAULT}); end
      do_reset();
      n_cmp++; if ({EN_ACC, EN_REG_F, EN_D_MEM} !== 3'b000) begin n_err++; $display("FAIL boot_en got=%b exp=000", {EN_ACC, EN_REG_F, EN_D_MEM}); end
      n_cmp++; if (PC !== 8'h00) begin n_err++; $display("FAIL boot_pc got=%h exp=00", PC); end
      step();
      for (int i = 0; i < 256; i++) begin
         n_cmp++; if (PC !== 8'(i)) begin n_err++; $display("FAIL seq_pc got=%h exp=%h", PC, 8'(i)); end
         step();
      end
      n_cmp++; if (PC !== 8'h00) begin n_err++; $display("FAIL wrap_pc got=%h exp=00", PC); end
   endtask

   task automatic test_alu();
      fill_nop();
      rom[0] = ins(5'b00010, 2'b00, 8'h2A);
      rom[1] = ins(5'b00001, 2'b11, 8'h03);
      rom[2] = ins(5'b00111, 2'b10, 8'h55);
      do_reset();
      n_cmp++; if (EN_ACC !== 1'b0) begin n_err++; $display("FAIL boot_acc_gate got=%b exp=0", EN_ACC); end
      step();
      n_cmp++; if ({EN_ACC, ALU_OUT, IN_B_SEL, IMM} !== {1'b1, 4'b0010, 2'b00, 8'h2A}) begin
         n_err++; $display("FAIL alu_imm got=%b_%b_%b_%h exp=1_0010_00_2a", EN_ACC, ALU_OUT, IN_B_SEL, IMM); end
      n_cmp++; if ({D_MEM_ADDR_MODE, EN_REG_F, EN_D_MEM} !== 3'b000) begin n_err++; $display("FAIL alu_imm_side got=%b exp=000", {D_MEM_ADDR_MODE, EN_REG_F, EN_D_MEM}); end
      step();
      n_cmp++; if ({IN_B_SEL, D_MEM_ADDR_MODE, REG_F_SEL, ALU_OUT} !== {2'b11, 1'b1, 4'h3, 4'b0001}) begin
         n_err++; $display("FAIL alu_ind got=%b_%b_%h_%b exp=11_1_3_0001", IN_B_SEL, D_MEM_ADDR_MODE, REG_F_SEL, ALU_OUT); end
      step();
      n_cmp++; if ({IN_B_SEL, D_MEM_ADDR_MODE, D_MEM_ADDR} !== {2'b10, 1'b0, 8'h55}) begin
         n_err++; $display("FAIL alu_direct got=%b_%b_%h exp=10_0_55", IN_B_SEL, D_MEM_ADDR_MODE, D_MEM_ADDR); end
   endtask

   task automatic test_branch();
      fill_nop();
      rom[8'h00] = ins(5'b10001, 2'b00, 8'h10);
      rom[8'h10] = ins(5'b10010, 2'b00, 8'h40);
      rom[8'h11] = ins(5'b10010, 2'b00, 8'h40);
      rom[8'h40] = ins(5'b10011, 2'b00, 8'h50);
      rom[8'h41] = ins(5'b10011, 2'b00, 8'h60);
      do_reset();
      step();
      step();
      n_cmp++; if (PC !== 8'h10) begin n_err++; $display("FAIL jmp got=%h exp=10", PC); end
      Z = 1'b0; step();
      n_cmp++; if (PC !== 8'h11) begin n_err++; $display("FAIL jz_not_taken got=%h exp=11", PC); end
      Z = 1'b1; step();
      n_cmp++; if (PC !== 8'h40) begin n_err++; $display("FAIL jz_taken got=%h exp=40", PC); end
      n_cmp++; if (EN_ACC !== 1'b0) begin n_err++; $display("FAIL branch_acc got=%b exp=0", EN_ACC); end
      Z = 1'b1; step();
      n_cmp++; if (PC !== 8'h41) begin n_err++; $display("FAIL jnz_not_taken got=%h exp=41", PC); end
      Z = 1'b0; step();
      n_cmp++; if (PC !== 8'h60) begin n_err++; $display("FAIL jnz_taken got=%h exp=60", PC); end
   endtask

   task automatic test_stack();
      logic [7:0] exp_pc [5];
      fill_nop();
      rom[8'h00] = ins(5'b10001, 2'b00, 8'h20);
      rom[8'h20] = ins(5'b10100, 2'b00, 8'h30);
      rom[8'h30] = ins(5'b10100, 2'b00, 8'h40);
      rom[8'h40] = ins(5'b10101, 2'b00, 8'h00);
      rom[8'h31] = ins(5'b10101, 2'b00, 8'h00);
      exp_pc = '{8'h20, 8'h30, 8'h40, 8'h31, 8'h21};
      do_reset();
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++; if (PC !== exp_pc[i]) begin n_err++; $display("FAIL nest_call_ret[%0d] got=%h exp=%h", i, PC, exp_pc[i]); end
      end
      n_cmp++; if (FAULT !== 1'b0) begin n_err++; $display("FAIL nest_no_fault got=%b exp=0", FAULT); end

      fill_nop();
      for (int i = 0; i < 5; i++) rom[i] = ins(5'b10100, 2'b00, 8'(i + 1));
      do_reset();
      step();
      for (int i = 0; i < 4; i++) step();
      n_cmp++; if ({PC, FAULT} !== {8'h04, 1'b0}) begin n_err++; $display("FAIL pre_overflow got=%h_%b exp=04_0", PC, FAULT); end
      step();
      n_cmp++; if ({PC, FAULT, HALTED} !== {8'h04, 1'b1, 1'b1}) begin n_err++; $display("FAIL overflow got=%h_%b_%b exp=04_1_1", PC, FAULT, HALTED); end
      rom[4] = ins(5'b00011, 2'b00, 8'h01);
      #1;
      n_cmp++; if ({EN_ACC, EN_REG_F, EN_D_MEM} !== 3'b000) begin n_err++; $display("FAIL fault_en got=%b exp=000", {EN_ACC, EN_REG_F, EN_D_MEM}); end
      step();
      n_cmp++; if ({PC, FAULT} !== {8'h04, 1'b1}) begin n_err++; $display("FAIL fault_sticky got=%h_%b exp=04_1", PC, FAULT); end

      fill_nop();
      rom[0] = ins(5'b10100, 2'b00, 8'h00);
      do_reset();
      step();
      step();
      n_cmp++; if ({PC, FAULT} !== {8'h00, 1'b0}) begin n_err++; $display("FAIL call_self got=%h_%b exp=00_0", PC, FAULT); end

      fill_nop();
      rom[0] = ins(5'b10101, 2'b00, 8'h00);
      do_reset();
      step();
      step();
      n_cmp++; if ({PC, FAULT, HALTED} !== {8'h00, 1'b1, 1'b1}) begin n_err++; $display("FAIL underflow got=%h_%b_%b exp=00_1_1", PC, FAULT, HALTED); end
   endtask

   task automatic test_store_halt();
      fill_nop();
      rom[0] = ins(5'b10111, 2'b00, 8'h80);
      rom[1] = ins(5'b11000, 2'b00, 8'h02);
      rom[2] = ins(5'b10110, 2'b00, 8'h05);
      rom[3] = ins(5'b11001, 2'b00, 8'h00);
      do_reset();
      n_cmp++; if (EN_D_MEM !== 1'b0) begin n_err++; $display("FAIL boot_dmem_gate got=%b exp=0", EN_D_MEM); end
      step();
      n_cmp++; if ({EN_D_MEM, D_MEM_ADDR_MODE, D_MEM_ADDR, EN_REG_F, EN_ACC} !== {1'b1, 1'b0, 8'h80, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL stm got=%b_%b_%h_%b_%b exp=1_0_80_0_0", EN_D_MEM, D_MEM_ADDR_MODE, D_MEM_ADDR, EN_REG_F, EN_ACC); end
      step();
      n_cmp++; if ({EN_D_MEM, D_MEM_ADDR_MODE, REG_F_SEL, EN_REG_F} !== {1'b1, 1'b1, 4'h2, 1'b0}) begin
         n_err++; $display("FAIL stmi got=%b_%b_%h_%b exp=1_1_2_0", EN_D_MEM, D_MEM_ADDR_MODE, REG_F_SEL, EN_REG_F); end
      step();
      n_cmp++; if ({EN_REG_F, REG_F_SEL, EN_D_MEM} !== {1'b1, 4'h5, 1'b0}) begin
         n_err++; $display("FAIL str got=%b_%h_%b exp=1_5_0", EN_REG_F, REG_F_SEL, EN_D_MEM); end
      step();
      n_cmp++; if ({PC, HALTED, EN_REG_F} !== {8'h03, 1'b0, 1'b0}) begin n_err++; $display("FAIL hlt_exec got=%h_%b_%b exp=03_0_0", PC, HALTED, EN_REG_F); end
      step();
      n_cmp++; if ({PC, HALTED, FAULT} !== {8'h03, 1'b1, 1'b0}) begin n_err++; $display("FAIL halted got=%h_%b_%b exp=03_1_0", PC, HALTED, FAULT); end
      rom[3] = ins(5'b10110, 2'b00, 8'h05);
      #1;
      n_cmp++; if ({EN_REG_F, EN_D_MEM, EN_ACC} !== 3'b000) begin n_err++; $display("FAIL halt_en got=%b exp=000", {EN_REG_F, EN_D_MEM, EN_ACC}); end
      step();
      n_cmp++; if ({PC, HALTED} !== {8'h03, 1'b1}) begin n_err++; $display("FAIL halt_sticky got=%h_%b exp=03_1", PC, HALTED); end
      #2;
      RST_N = 1'b0;
      #1;
      n_cmp++; if ({PC, HALTED} !== {8'h00, 1'b0}) begin n_err++; $display("FAIL async_rst got=%h_%b exp=00_0", PC, HALTED); end
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_loop();
      logic [7:0] exp_pc [4];
      int n;
      fill_nop();
      rom[0] = ins(5'b11010, 2'b00, 8'h03);
      rom[1] = ins(5'b11011, 2'b00, 8'h01);
`ifdef CPU_CTRL_LOOP_EN
      exp_pc = '{8'h01, 8'h01, 8'h01, 8'h02};
      n = 4;
`else
      exp_pc = '{8'h01, 8'h02, 8'h03, 8'h04};
      n = 2;
`endif
      do_reset();
      step();
      for (int i = 0; i < n; i++) begin
         step();
         n_cmp++; if (PC !== exp_pc[i]) begin n_err++; $display("FAIL loop_pc[%0d] got=%h exp=%h", i, PC, exp_pc[i]); end
         n_cmp++; if ({EN_ACC, EN_REG_F, EN_D_MEM} !== 3'b000) begin n_err++; $display("FAIL loop_en[%0d] got=%b exp=000", i, {EN_ACC, EN_REG_F, EN_D_MEM}); end
      end
   endtask

   initial begin
      RST_N = 1'b0;
      Z = 1'b0;
      test_reset();
      test_alu();
      test_branch();
      test_stack();
      test_store_halt();
      test_loop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Control/sequencing unit that drives the datapath control interface of the one-cycle CPU: register-file, data-memory, B-source, ALU-op and accumulator enables.
- Consumes the datapath Z flag.
- Owns the program counter, the call stack and the run/halt/fault state.
- Fetches one instruction per cycle from an asynchronous-read program ROM; every instruction retires in one cycle.

Parameters:
- WIDTH, 8, data/operand/PC width
- IWIDTH, 5, opcode width; ALU op field is IWIDTH-1
- REG_F_SEL_SIZE, 4, register-file select width
- IN_B_SEL_SIZE, 2, B-source select width
- STACK_DEPTH, 4, call-stack entries (power of 2, >=2)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- INSTR  in  IWIDTH+IN_B_SEL_SIZE+WIDTH  instruction word {OPC, BSRC, OPERAND}
- Z  in  1  zero flag from datapath
- PC  out  WIDTH  program ROM address
- REG_F_SEL  out  REG_F_SEL_SIZE  register select
- EN_REG_F  out  1  register write enable
- D_MEM_ADDR  out  WIDTH  direct data-memory address
- D_MEM_ADDR_MODE  out  1  0 = operand address, 1 = register-indirect
- EN_D_MEM  out  1  data-memory write enable
- IN_B_SEL  out  IN_B_SEL_SIZE  ALU B source: 00 IMM, 01 reg, 1x mem
- IMM  out  WIDTH  immediate
- ALU_OUT  out  IWIDTH-1  ALU operation
- EN_ACC  out  1  accumulator load
- HALTED  out  1  core in HALT or FAULT
- FAULT  out  1  stack overflow/underflow

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State=BOOT, PC=0, stack pointer SP=0.
  - Enables EN_REG_F/EN_D_MEM/EN_ACC=0; HALTED=0, FAULT=0.
- States:
  - BOOT: one cycle after reset release, all enables 0, PC held at 0, goes to RUN. This gives the datapath flag register its own clear cycle.
  - RUN: executes INSTR.
  - HALT: sticky. PC frozen, enables 0, HALTED=1.
  - FAULT: sticky. As HALT plus FAULT=1.
  - HALT and FAULT exit only via reset.
- Decode in RUN is combinational from INSTR. Field aliases:
  - OPERAND drives IMM and D_MEM_ADDR.
  - OPERAND[REG_F_SEL_SIZE-1:0] drives REG_F_SEL.
  - Default PC_next = PC+1, wrapping 0xFF to 0x00.
- OPC[IWIDTH-1]=0, ALU op:
  - ALU_OUT=OPC[IWIDTH-2:0], EN_ACC=1, IN_B_SEL=BSRC.
  - D_MEM_ADDR_MODE=1 only when BSRC=11; BSRC=10 is direct.
- OPC[IWIDTH-1]=1, control op (ALU_OUT=0, EN_ACC=0):
  - 10000 NOP.
  - 10001 JMP: PC_next=OPERAND.
  - 10010 JZ: PC_next=OPERAND if Z=1.
  - 10011 JNZ: PC_next=OPERAND if Z=0.
  - 10100 CALL: push PC+1, PC_next=OPERAND.
  - 10101 RET: pop into PC_next.
  - 10110 STR: EN_REG_F=1.
  - 10111 STM: EN_D_MEM=1, mode 0.
  - 11000 STMI: EN_D_MEM=1, mode 1.
  - 11001 HLT: next state HALT, PC not advanced.
  - Others: executed as NOP.
- Z is sampled in the same cycle as the branch.
- Stack:
  - CALL with SP=STACK_DEPTH goes to FAULT: no push, PC not advanced.
  - RET with SP=0 goes to FAULT.
  - CALL to self (OPERAND=PC) is legal.
  - Stack contents are not cleared by reset; only SP is.
- Enables are gated by state==RUN, so no write is ever issued in BOOT, HALT or FAULT.

Optional Feature:
- Macro CPU_CTRL_LOOP_EN adds an internal WIDTH-bit loop counter LC (reset 0) and two opcodes:
  - 11010 LDC: LC<=OPERAND.
  - 11011 DJNZ: LC<=LC-1, then PC_next=OPERAND if the decremented value is nonzero. DJNZ with LC=0 wraps LC to 0xFF and branches.
- Neither opcode drives any datapath enable.
- Without the macro, 11010 and 11011 execute as NOP and LC does not exist.

Test Plan:
1. Reset with ROM all NOP, release RST_N → BOOT cycle PC=0 and all enables 0; then PC=0,1,2,…; after 0xFF, PC wraps to 0x00.
2. INSTR={00010,00,0x2A} → EN_ACC=1, ALU_OUT=0010, IN_B_SEL=00, IMM=0x2A. INSTR={00001,11,0x03} → IN_B_SEL=11, D_MEM_ADDR_MODE=1, REG_F_SEL=3.
3. At PC=0x10, JZ 0x40 with Z=0 → PC=0x11. At PC=0x11, JZ 0x40 with Z=1 → PC=0x40. At PC=0x40, JNZ 0x50 with Z=1 → PC=0x41.
4. Nested CALLs 0x20→0x30→0x40 then 2× RET → PC=0x31, then 0x21. A 5th nested CALL with STACK_DEPTH=4 → FAULT=1, HALTED=1, PC frozen, enables 0. A RET at SP=0 → FAULT.
5. STM 0x80, STMI r2, STR r5 → EN_D_MEM/EN_REG_F pulse exactly one cycle with the correct mode and select. HLT → HALTED=1, PC stays, no enables until RST_N pulse. Assert RST_N low mid-HALT → immediate PC=0.
6. With CPU_CTRL_LOOP_EN: LDC 3, then DJNZ to self → the DJNZ executes 3 times, then PC advances. Without the macro, the same program → DJNZ executes once as NOP.
